// File: rtl/reduction_pkg.sv
// Shared types, constants and the result-selection helper for the reduction scheduler.
package reduction_pkg;

  // Op codes carried with each transaction; 6 and 7 are illegal.
  typedef enum logic [2:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpNand = 3'd2,
    OpNor  = 3'd3,
    OpXor  = 3'd4,
    OpXnor = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  // Identity values of the three folds.
  localparam logic AndAccInit = 1'b1;
  localparam logic OrAccInit  = 1'b0;
  localparam logic XorAccInit = 1'b0;

  function automatic logic op_illegal(logic [2:0] op);
    return op > 3'd5;
  endfunction

  // Pick the result bit for an op from the folded accumulators; illegal ops yield 0.
  function automatic logic op_apply(logic [2:0] op, logic and_acc, logic or_acc,
                                    logic xor_acc);
    logic r;
    r = 1'b0;
    case (op)
      OpAnd:   r = and_acc;
      OpOr:    r = or_acc;
      OpNand:  r = ~and_acc;
      OpNor:   r = ~or_acc;
      OpXor:   r = xor_acc;
      OpXnor:  r = ~xor_acc;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduction_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping.
module reduction_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int unsigned IdW = $clog2(N_REQ);
  localparam logic [IdW:0] NumReq = (IdW + 1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;
  logic [IdW:0]       sum;

  // Rotate valids so ptr_i lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl     = {valid_i, valid_i};
    shifted = dbl >> ptr_i;
    rot     = shifted[N_REQ-1:0];
    any_o   = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        sum   = {1'b0, ptr_i} + k[IdW:0];
        if (sum >= NumReq) begin
          sum = sum - NumReq;
        end
        idx_o = sum[IdW-1:0];
      end
    end
    gnt_o = '0;
    for (int unsigned m = 0; m < N_REQ; m++) begin
      gnt_o[m] = any_o && (idx_o == m[IdW-1:0]);
    end
  end

endmodule

// File: rtl/reduction_sched.sv
// Round-robin scheduler sharing one AND/OR/XOR reduction engine among N_REQ requesters.
module reduction_sched
  import reduction_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*3-1:0]       req_op,
  input  logic [N_REQ*LEN_W-1:0]   req_len,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_bit,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [2:0]               res_op,
  output logic                     res_err
);

  localparam int unsigned IdW = $clog2(N_REQ);

  state_e           state_q;
  logic [IdW-1:0]   rr_ptr_q;
  logic [IdW-1:0]   gnt_id_q;
  logic [N_REQ-1:0] req_ready_q;
  logic [2:0]       op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic             and_acc_q, or_acc_q, xor_acc_q;
  logic             res_valid_q, res_bit_q, res_err_q;
  logic [2:0]       res_op_q;
  logic [IdW-1:0]   res_id_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdW-1:0]   arb_idx;
  logic             arb_any;

  logic              sel_valid, sel_ready;
  logic [DATA_W-1:0] sel_data;
  logic [2:0]        sel_op;
  logic [LEN_W-1:0]  sel_len;
  logic              beat_fire, first_beat, last_beat;
  logic [2:0]        cur_op;
  logic [LEN_W-1:0]  cur_len;
  logic              and_d, or_d, xor_d;
  logic              res_bit_d, res_err_d;
  logic [IdW-1:0]    rr_ptr_d;

  reduction_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .valid_i(req_valid),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  // Mux the granted requester's fields onto the engine.
  always_comb begin
    sel_valid = 1'b0;
    sel_ready = 1'b0;
    sel_data  = '0;
    sel_op    = '0;
    sel_len   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_id_q == i[IdW-1:0]) begin
        sel_valid = req_valid[i];
        sel_ready = req_ready_q[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_op    = req_op[i*3 +: 3];
        sel_len   = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Beat transfer, fold update and result selection for the current beat.
  always_comb begin
    beat_fire  = (state_q == StBusy) && sel_valid && sel_ready;
    first_beat = (beat_cnt_q == '0);
    // op/len come straight from the bus on the first beat, from the latch afterwards.
    cur_op     = first_beat ? sel_op : op_q;
    cur_len    = first_beat ? sel_len : len_q;
    last_beat  = (beat_cnt_q == cur_len);
    and_d      = and_acc_q & (&sel_data);
    or_d       = or_acc_q | (|sel_data);
    xor_d      = xor_acc_q ^ (^sel_data);
    res_bit_d  = op_apply(cur_op, and_d, or_d, xor_d);
    res_err_d  = op_illegal(cur_op);
    rr_ptr_d   = (gnt_id_q == IdW'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
  end

  // Scheduler FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      req_ready_q <= '0;
      op_q        <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      and_acc_q   <= AndAccInit;
      or_acc_q    <= OrAccInit;
      xor_acc_q   <= XorAccInit;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_err_q   <= 1'b0;
      res_op_q    <= '0;
      res_id_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            gnt_id_q    <= arb_idx;
            req_ready_q <= arb_gnt;
            beat_cnt_q  <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          // A dropped valid simply stalls here with the grant held.
          if (beat_fire) begin
            and_acc_q <= and_d;
            or_acc_q  <= or_d;
            xor_acc_q <= xor_d;
            if (first_beat) begin
              op_q  <= sel_op;
              len_q <= sel_len;
            end
            if (last_beat) begin
              req_ready_q <= '0;
              res_valid_q <= 1'b1;
              res_bit_q   <= res_bit_d;
              res_err_q   <= res_err_d;
              res_op_q    <= cur_op;
              res_id_q    <= gnt_id_q;
              state_q     <= StResp;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        StResp: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            and_acc_q   <= AndAccInit;
            or_acc_q    <= OrAccInit;
            xor_acc_q   <= XorAccInit;
            beat_cnt_q  <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign res_id    = res_id_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_reduction_sched.sv
// Directed self-checking bench for reduction_sched (N_REQ=4, DATA_W=8, LEN_W=4).
module tb_reduction_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [15:0] req_len;
  logic [31:0] req_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_bit;
  logic [1:0]  res_id;
  logic [2:0]  res_op;
  logic        res_err;

  int checks = 0;
  int errors = 0;

  // Requester-side model state.
  logic [3:0] vld;
  logic [3:0] rearm;
  logic [2:0] topc[4];
  logic [3:0] tlen[4];
  logic [7:0] bt[4][16];
  int         bidx[4];
  int         pulses[4];

  // Results observed at handshake.
  logic [1:0] log_id[$];
  logic       log_bit[$];
  logic [2:0] log_op[$];
  logic       log_err[$];

  reduction_sched #(
    .N_REQ (4),
    .DATA_W(8),
    .LEN_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_len  (req_len),
    .req_data (req_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_bit  (res_bit),
    .res_id   (res_id),
    .res_op   (res_op),
    .res_err  (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = vld[i];
      req_op[i*3 +: 3]    = topc[i];
      req_len[i*4 +: 4]   = tlen[i];
      req_data[i*8 +: 8]  = bt[i][bidx[i]];
    end
  endtask

  task automatic load(input int id, input logic [2:0] op, input int len, input logic [7:0] fill,
                      input logic rep);
    topc[id]   = op;
    tlen[id]   = len[3:0];
    for (int k = 0; k < 16; k++) bt[id][k] = fill;
    bidx[id]   = 0;
    pulses[id] = 0;
    rearm[id]  = rep;
    vld[id]    = 1'b1;
    apply();
  endtask

  // One clock: called and returning at a falling edge.
  task automatic cycle();
    logic [3:0] fire;
    fire = req_valid & req_ready;
    if (res_valid && res_ready) begin
      log_id.push_back(res_id);
      log_bit.push_back(res_bit);
      log_op.push_back(res_op);
      log_err.push_back(res_err);
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        pulses[i]++;
        if (bidx[i] == int'(tlen[i])) begin
          bidx[i] = 0;
          if (!rearm[i]) vld[i] = 1'b0;
        end else begin
          bidx[i]++;
        end
      end
    end
    apply();
  endtask

  task automatic clear_log();
    log_id.delete();
    log_bit.delete();
    log_op.delete();
    log_err.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = '0;
    apply();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    clear_log();
  endtask

  task automatic expect_res(input string tag, input logic [1:0] id, input logic b,
                            input logic [2:0] op, input logic err);
    int n;
    n = 0;
    while (log_id.size() == 0 && n < 300) begin
      cycle();
      n++;
    end
    if (log_id.size() == 0) begin
      chk({tag, "_timeout"}, 32'(log_id.size()), 32'd1);
    end else begin
      chk({tag, "_id"}, 32'(log_id.pop_front()), 32'(id));
      chk({tag, "_bit"}, 32'(log_bit.pop_front()), 32'(b));
      chk({tag, "_op"}, 32'(log_op.pop_front()), 32'(op));
      chk({tag, "_err"}, 32'(log_err.pop_front()), 32'(err));
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    res_ready = 1'b1;
    vld       = '0;
    rearm     = '0;
    for (int i = 0; i < 4; i++) begin
      topc[i]   = '0;
      tlen[i]   = '0;
      bidx[i]   = 0;
      pulses[i] = 0;
      for (int k = 0; k < 16; k++) bt[i][k] = '0;
    end
    apply();
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_bit", 32'(res_bit), 32'h0);
    chk("rst_res_id", 32'(res_id), 32'h0);
    chk("rst_res_op", 32'(res_op), 32'h0);
    chk("rst_res_err", 32'(res_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat AND of 0x00 on req0, with cycle-accurate latency.
    load(0, 3'd0, 0, 8'h00, 1'b0);
    chk("idle_no_ready", 32'(req_ready), 32'h0);
    cycle();
    chk("grant_ready", 32'(req_ready), 32'h1);
    chk("busy_no_valid", 32'(res_valid), 32'h0);
    cycle();
    chk("lat_valid", 32'(res_valid), 32'h1);
    chk("lat_ready_off", 32'(req_ready), 32'h0);
    chk("and_bit", 32'(res_bit), 32'h0);
    chk("and_id", 32'(res_id), 32'h0);
    chk("and_op", 32'(res_op), 32'h0);
    cycle();
    chk("and_hs_logged", 32'(log_id.size()), 32'd1);
    clear_log();

    load(0, 3'd3, 0, 8'h00, 1'b0);
    expect_res("nor", 2'd0, 1'b1, 3'd3, 1'b0);
    load(0, 3'd2, 0, 8'hFF, 1'b0);
    expect_res("nand", 2'd0, 1'b0, 3'd2, 1'b0);

    // Three-beat XOR/XNOR on req1: parity 0^1^0 = 1.
    load(1, 3'd4, 2, 8'h00, 1'b0);
    bt[1][0] = 8'hAA; bt[1][1] = 8'h01; bt[1][2] = 8'h33;
    apply();
    expect_res("xor", 2'd1, 1'b1, 3'd4, 1'b0);
    chk("xor_pulses", 32'(pulses[1]), 32'd3);
    load(1, 3'd5, 2, 8'h00, 1'b0);
    bt[1][0] = 8'hAA; bt[1][1] = 8'h01; bt[1][2] = 8'h33;
    apply();
    expect_res("xnor", 2'd1, 1'b0, 3'd5, 1'b0);
    chk("xnor_pulses", 32'(pulses[1]), 32'd3);

    // Maximum length: 16 beats; a zero bit in the final beat must still be folded.
    load(2, 3'd0, 15, 8'hFF, 1'b0);
    expect_res("lenmax_ones", 2'd2, 1'b1, 3'd0, 1'b0);
    chk("lenmax_pulses", 32'(pulses[2]), 32'd16);
    load(2, 3'd0, 15, 8'hFF, 1'b0);
    bt[2][15] = 8'hFE;
    apply();
    expect_res("lenmax_last", 2'd2, 1'b0, 3'd0, 1'b0);

    // Round robin between req0 and req2.
    do_reset();
    load(0, 3'd1, 0, 8'h01, 1'b1);
    load(2, 3'd1, 0, 8'h01, 1'b1);
    expect_res("rr02_a", 2'd0, 1'b1, 3'd1, 1'b0);
    expect_res("rr02_b", 2'd2, 1'b1, 3'd1, 1'b0);
    expect_res("rr02_c", 2'd0, 1'b1, 3'd1, 1'b0);
    expect_res("rr02_d", 2'd2, 1'b1, 3'd1, 1'b0);

    // Round robin across req0, req2, req3.
    do_reset();
    load(0, 3'd1, 0, 8'h01, 1'b1);
    load(2, 3'd1, 0, 8'h01, 1'b1);
    load(3, 3'd1, 0, 8'h01, 1'b1);
    expect_res("rr023_a", 2'd0, 1'b1, 3'd1, 1'b0);
    expect_res("rr023_b", 2'd2, 1'b1, 3'd1, 1'b0);
    expect_res("rr023_c", 2'd3, 1'b1, 3'd1, 1'b0);
    expect_res("rr023_d", 2'd0, 1'b1, 3'd1, 1'b0);

    // Result held under back-pressure, then one idle cycle before the next grant.
    do_reset();
    res_ready = 1'b0;
    load(1, 3'd0, 0, 8'hFF, 1'b1);
    n = 0;
    while (!res_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("hold_seen", 32'(res_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("hold_valid", 32'(res_valid), 32'h1);
      chk("hold_bit", 32'(res_bit), 32'h1);
      chk("hold_id", 32'(res_id), 32'h1);
      chk("hold_op", 32'(res_op), 32'h0);
      chk("hold_ready", 32'(req_ready), 32'h0);
    end
    res_ready = 1'b1;
    cycle();
    chk("post_idle_valid", 32'(res_valid), 32'h0);
    chk("post_idle_ready", 32'(req_ready), 32'h0);
    cycle();
    chk("regrant_ready", 32'(req_ready), 32'h2);

    // Illegal op still consumes len+1 beats; next legal op clears the flag.
    do_reset();
    load(0, 3'd6, 1, 8'hFF, 1'b0);
    expect_res("illegal", 2'd0, 1'b0, 3'd6, 1'b1);
    chk("illegal_pulses", 32'(pulses[0]), 32'd2);
    load(0, 3'd0, 0, 8'hFF, 1'b0);
    expect_res("legal_after", 2'd0, 1'b1, 3'd0, 1'b0);

    // Reset after two beats of a four-beat OR discards the partial result.
    load(0, 3'd1, 3, 8'h00, 1'b0);
    bt[0][0] = 8'h10;
    apply();
    n = 0;
    while (pulses[0] < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("mid_two_beats", 32'(pulses[0]), 32'd2);
    rst_n = 1'b0;
    vld   = '0;
    apply();
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_valid", 32'(res_valid), 32'h0);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    chk("mid_no_result", 32'(log_id.size()), 32'd0);
    chk("mid_valid_low", 32'(res_valid), 32'h0);
    load(0, 3'd1, 0, 8'h00, 1'b0);
    expect_res("acc_cleared", 2'd0, 1'b0, 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduction_sched.md
Name: reduction_sched

Overview:
Round-robin scheduler that shares one sequential reduction engine among N_REQ requesters. Each requester submits a multi-beat vector transaction with an op code. The block grants one requester at a time and folds every beat into AND/OR/XOR accumulators. It then returns a single result bit tagged with the requester ID. It sits between requester ports and a consumer of reduction results.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, bits per beat
LEN_W, 4, width of beat-count field; transaction length = req_len+1 beats (1..2^LEN_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  per-requester beat valid
req_ready  out  N_REQ  per-requester beat accept
req_op  in  N_REQ*3  op code per requester: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 illegal
req_len  in  N_REQ*LEN_W  beats minus one, per requester
req_data  in  N_REQ*DATA_W  beat data, per requester
res_valid  out  1  result available
res_ready  in  1  consumer accept
res_bit  out  1  reduction result
res_id  out  $clog2(N_REQ)  granted requester index
res_op  out  3  op code of the transaction
res_err  out  1  illegal op code flag

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, rr_ptr=0
  - all req_ready=0, res_valid=0, res_bit=0, res_id=0, res_op=0, res_err=0
  - accumulators: and_acc=1, or_acc=0, xor_acc=0
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - if any req_valid is set, grant the first valid index at or after rr_ptr (wrapping) and go to BUSY next cycle.
  - req_ready stays 0 in IDLE, so arbitration costs 1 cycle.
- BUSY:
  - req_ready[g]=1 only for granted index g; all others are 0.
  - A beat transfers when req_valid[g]&&req_ready[g].
  - First beat latches op and len into registers. Later changes to req_op or req_len are ignored.
  - Each beat updates: and_acc&=&data; or_acc|=|data; xor_acc^=^data; beat_cnt++.
  - The beat with beat_cnt==len_latched is last; the next state is RESP.
  - If req_valid[g] drops mid-transaction, the block stalls with the grant held. There is no timeout, and no other requester is served.
- RESP:
  - res_valid=1. res_bit, res_id and res_op are held stable until res_valid&&res_ready.
  - res_bit by op: AND=and_acc, OR=or_acc, NAND=~and_acc, NOR=~or_acc, XOR=xor_acc, XNOR=~xor_acc.
  - Op 6/7: res_err=1, res_bit=0, but the block still consumes len+1 beats.
  - On handshake: rr_ptr=(g+1) mod N_REQ, accumulators reinitialised, go to IDLE. Back-to-back transactions are therefore separated by 1 idle cycle.
- Latency, len=0 with valid held: grant at cycle 1, beat accepted at cycle 1 (BUSY), res_valid=1 at cycle 2.
- Minimum transaction period is len+3 cycles with res_ready=1.
- len=max: counter must not overflow; beat_cnt is LEN_W bits, compared before increment.
- Reset mid-transaction: the partial result is discarded, no res_valid is produced, and rr_ptr returns to 0.
- Requester valid without grant: no data is consumed and no ordering is guaranteed beyond round-robin.

Decomposition:
- Package reduction_pkg:
  - op code enum (OP_AND..OP_XNOR)
  - FSM state enum
  - accumulator-init constants
  - function op_apply(op, and_acc, or_acc, xor_acc)
- One sub-module, reduction_rr_arbiter: combinational pick of the first valid at or after rr_ptr. Outputs a one-hot grant and an index.

Test Plan:
- req0, op AND, len=0, data 8'h00 -> res_bit=0, res_id=0. Repeat with NOR -> res_bit=1. Repeat with 8'hFF NAND -> res_bit=0.
- req1, op XOR, len=2, beats 8'hAA,8'h01,8'h33 -> parity 0^1^0 -> res_bit=1. XNOR on the same beats -> res_bit=0. Exactly 3 req_ready pulses.
- req0 and req2 valid continuously, single-beat -> grant order 0,2,0,2. Add req3 -> order 0,2,3,0.
- res_ready=0 for 5 cycles after res_valid -> res_bit/res_id/res_op stable, all req_ready=0. After accept, IDLE for 1 cycle.
- req0 op 6, len=1 -> 2 beats consumed, res_err=1, res_bit=0. Next legal transaction -> res_err=0.
- rst_n low after beat 2 of a 4-beat OR with beat 1 = 8'h10 -> no res_valid. A new 1-beat OR of 8'h00 -> res_bit=0, proving the accumulator cleared.
